stack: RTL and testbench
========================

# stack

Synchronous LIFO stack of fixed depth storing WIDTH-bit words, used as a general-purpose data stack (e.g. operand stack of a small datapath).
- Push and pop are per-clock enables, sampled on each rising edge of `clk`.
- The current top entry and the most recently popped value are always visible on outputs.
- Status flags report full, empty and occupancy.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of entries, ≥2; need not be a power of two.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `value` input WIDTH: data word to push.
- `push` input 1: push enable, sampled each rising edge.
- `pop` input 1: pop enable, sampled each rising edge.
- `top` output WIDTH: entry currently on top of the stack; 0 when empty.
- `lastPop` output WIDTH: value removed by the most recent successful pop.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output $clog2(DEPTH+1): number of stored entries.

## Operation
- State: storage array `mem[0..DEPTH-1]`, stack pointer `sp` (= count), register `lastPop_r`.
- push=1, pop=0, not full:
  - `mem[sp] <= value`, `sp <= sp+1`.
- push=1, pop=0, full:
  - Push ignored; no state change.
- pop=1, push=0, not empty:
  - `lastPop_r <= mem[sp-1]`, `sp <= sp-1`.
- pop=1, push=0, empty:
  - Pop ignored; `lastPop` keeps its previous value.
- push=1, pop=1, not empty (replace):
  - `lastPop_r <= mem[sp-1]`, `mem[sp-1] <= value`, `sp` unchanged.
  - This applies even when full.
- push=1, pop=1, empty:
  - Behaves as a plain push: `mem[0] <= value`, `sp <= 1`, `lastPop` unchanged.
- Both low: hold.
- Held enables act every cycle:
  - push held N cycles pushes N words (until full).
  - pop held drains one entry per cycle, then idles at empty.
- `top` = `mem[sp-1]` when sp>0, else 0.
- `lastPop`, `full`, `empty` and `count` are derived combinationally from registered state; no glitches on data beyond that.
- Memory contents above `sp` are don't-care and never observable.

## Timing
- Reset (asynchronous assert, release synchronous to next edge is the integrator's responsibility):
  - sp=0, `lastPop`=0, `top`=0, `empty`=1, `full`=0, `count`=0.
  - Memory need not be cleared.
- Latency: effect of push/pop at rising edge k visible on `top`, `lastPop`, `count` and the flags immediately after edge k (same cycle, zero added latency).
- No handshake: the caller must observe `full`/`empty`. Illegal operations are silently dropped, never corrupting state.
- Reset asserted mid-sequence: stack empties immediately regardless of push/pop.
- `value` is sampled only at the rising edge; changes between edges have no effect.

## Structure
- No shared package required; WIDTH and DEPTH are module parameters.
- Pointer width is a localparam `$clog2(DEPTH+1)`.
- One natural sub-module, `stack_ram`: DEPTH×WIDTH register array with a single synchronous write port and one asynchronous read port at address sp-1.
- The top level holds the pointer, `lastPop` register and operation decode.

## Test plan
- Reset then idle: `top`=0, `lastPop`=0, `empty`=1, `count`=0.
- Push 0,1,2,3,4,5,6 on seven consecutive edges:
  - `top` tracks each value one edge later.
  - `count`=7 at the end.
- Hold pop for 10 edges after that:
  - `lastPop` sequence 6,5,4,3,2,1,0.
  - `top` steps 5…0 then 0 with `empty`=1.
  - Extra pops leave `lastPop`=0 and `count`=0.
- Fill to DEPTH=16 with 0x10..0x1F, then push 0xAA:
  - `full`=1, `top`=0x1F, `count`=16 unchanged.
- Simultaneous push 0x55 and pop with `top`=0x1F:
  - `lastPop`=0x1F, `top`=0x55, `count` unchanged.
  - Same with push 0x77 and pop on an empty stack: `top`=0x77, `count`=1, `lastPop` unchanged.
- Assert reset asynchronously mid-push-burst (between edges):
  - Outputs clear at once to reset values.
  - The first push after release stores into `mem[0]`.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared operation encoding for the LIFO stack and the decode that picks one per edge.
// Illegal requests (push when full, pop when empty) decode to OP_IDLE so state is never disturbed.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // Push+pop on an empty stack degrades to a plain push.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_e op;
    op = OP_IDLE;
    if (push && pop && !empty)
      op = OP_REPLACE;
    else if (push && !full)
      op = OP_PUSH;
    else if (pop && !push && !empty)
      op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Read data follows rd_addr combinationally; no backpressure, writes always land.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/stack.sv
// LIFO stack with push/pop/replace per clock; results visible right after the active edge.
// No handshake: caller watches full/empty, illegal operations are dropped without side effects.
module stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           value,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           lastPop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0]    sp;
  logic [WIDTH-1:0] lastpop_r;
  logic [WIDTH-1:0] rd_dat;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    wr_addr;
  logic             we;
  op_e              op;

  assign full     = (sp == PW'(DEPTH));
  assign empty    = (sp == '0);
  assign count    = sp;
  assign lastPop  = lastpop_r;
  assign op       = decode_op(push, pop, full, empty);

  // When sp is 0 this address wraps; top is forced to 0 in that case.
  assign top_addr = AW'(sp - PW'(1));
  assign top      = empty ? '0 : rd_dat;

  assign we       = (op == OP_PUSH) || (op == OP_REPLACE);
  assign wr_addr  = (op == OP_REPLACE) ? top_addr : AW'(sp);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_dat  (value),
    .rd_addr (top_addr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      lastpop_r <= '0;
    end else begin
      case (op)
        OP_PUSH:    sp <= sp + PW'(1);
        OP_POP: begin
          lastpop_r <= rd_dat;
          sp        <= sp - PW'(1);
        end
        OP_REPLACE: lastpop_r <= rd_dat;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack.sv
// Directed bench for stack: push/pop sequences, full/empty boundaries, replace and async reset.
module tb_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] value;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] lastPop;
  logic             full;
  logic             empty;
  logic [4:0]       count;

  int checks;
  int failures;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .push    (push),
    .pop     (pop),
    .top     (top),
    .lastPop (lastPop),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [7:0] e_top,
                             input logic [7:0] e_last, input logic [4:0] e_cnt,
                             input logic e_full, input logic e_empty);
    checks++;
    if (top !== e_top || lastPop !== e_last || count !== e_cnt ||
        full !== e_full || empty !== e_empty) begin
      failures++;
      $display("FAIL %s: got top=%h lastPop=%h count=%0d full=%b empty=%b, expected top=%h lastPop=%h count=%0d full=%b empty=%b",
               name, top, lastPop, count, full, empty, e_top, e_last, e_cnt, e_full, e_empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; value = '0;
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();
    check_state("reset_idle", 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic test_push_seq();
    for (int i = 0; i < 7; i++) begin
      value = 8'(i); push = 1'b1;
      cycle();
      check_state($sformatf("push_%0d", i), 8'(i), 8'h00, 5'(i + 1), 1'b0, 1'b0);
    end
    push = 1'b0;
  endtask

  task automatic test_pop_drain();
    int n;
    pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n = (i < 7) ? 6 - i : 0;
      check_state($sformatf("pop_%0d", i), (n > 0) ? 8'(n - 1) : 8'h00,
                  8'(n), 5'(n), 1'b0, (n == 0));
    end
    pop = 1'b0;
  endtask

  task automatic test_full();
    push = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      value = 8'h10 + 8'(i);
      cycle();
    end
    check_state("fill", 8'h1F, 8'h00, 5'd16, 1'b1, 1'b0);
    value = 8'hAA;
    cycle();
    check_state("push_when_full", 8'h1F, 8'h00, 5'd16, 1'b1, 1'b0);
    push = 1'b0;
  endtask

  task automatic test_replace();
    value = 8'h55; push = 1'b1; pop = 1'b1;
    cycle();
    check_state("replace_full", 8'h55, 8'h1F, 5'd16, 1'b1, 1'b0);
    push = 1'b0;
    cycle();
    check_state("pop_replaced", 8'h1E, 8'h55, 5'd15, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle();
    check_state("drain_after_replace", 8'h00, 8'h10, 5'd0, 1'b0, 1'b1);
    value = 8'h77; push = 1'b1;
    cycle();
    check_state("replace_empty", 8'h77, 8'h10, 5'd1, 1'b0, 1'b0);
    push = 1'b0; pop = 1'b0;
    cycle();
    check_state("hold", 8'h77, 8'h10, 5'd1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      value = 8'h80 + 8'(i);
      cycle();
    end
    check_state("burst", 8'h82, 8'h10, 5'd4, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_state("async_reset_now", 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);
    cycle();
    check_state("reset_held_push", 8'h00, 8'h00, 5'd0, 1'b0, 1'b1);
    reset = 1'b0;
    value = 8'h99;
    cycle();
    check_state("first_after_reset", 8'h99, 8'h00, 5'd1, 1'b0, 1'b0);
    value = 8'h9A;
    cycle();
    push = 1'b0; pop = 1'b1;
    cycle();
    check_state("pop_9a", 8'h99, 8'h9A, 5'd1, 1'b0, 1'b0);
    cycle();
    check_state("pop_mem0", 8'h00, 8'h99, 5'd0, 1'b0, 1'b1);
    pop = 1'b0;
  endtask

  task automatic test_value_between_edges();
    value = 8'h3C; push = 1'b1;
    #2 value = 8'hC3;
    @(negedge clk);
    value = 8'h3C;
    cycle();
    push = 1'b0;
    value = 8'hFF;
    #3;
    check_state("value_sampled_at_edge", 8'h3C, 8'h99, 5'd1, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_push_seq();
    test_pop_drain();
    test_full();
    test_replace();
    test_async_reset();
    test_value_between_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
